// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: W-bit adder built from a single N-bit ripple-carry slice,
// reused once per clock over WORDS slices (least-significant slice first).
// Optional subtract mode is compiled in when macro RCA_SEQ_SUB_EN is defined;
// it adds an input port 'sub'. The default build performs addition only.

// N-bit ripple-carry adder slice: a chain of full adders.
module rca_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c_s;

  // Ripple the carry from bit 0 upwards through the full-adder chain.
  always_comb begin
    s      = '0;
    c_s    = '0;
    c_s[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]       = a[i] ^ b[i] ^ c_s[i];
      c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    co = c_s[N];
  end

endmodule

module rca_seq_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  input  logic                 Cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 Cout
);

  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_r;
  logic [KW-1:0] k_r;
  logic          carry_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  acc_r;
  logic          busy_r;
  logic          done_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;

  logic [W-1:0]  op_b_s;
  logic          op_carry_s;
  logic [N-1:0]  slice_a_s;
  logic [N-1:0]  slice_b_s;
  logic [N-1:0]  slice_sum_s;
  logic          slice_cout_s;
  logic [W-1:0]  acc_next_s;

  // Operand conditioning: subtraction stores ~B and forces the initial carry to 1.
  always_comb begin
`ifdef RCA_SEQ_SUB_EN
    if (sub) begin
      op_b_s     = ~B;
      op_carry_s = 1'b1;
    end else begin
      op_b_s     = B;
      op_carry_s = Cin;
    end
`else
    op_b_s     = B;
    op_carry_s = Cin;
`endif
  end

  // Select slice k of the latched operands and merge the slice result into the accumulator.
  always_comb begin
    slice_a_s                 = a_r[k_r * N +: N];
    slice_b_s                 = b_r[k_r * N +: N];
    acc_next_s                = acc_r;
    acc_next_s[k_r * N +: N]  = slice_sum_s;
  end

  rca_slice #(.N(N)) u_slice (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_cout_s)
  );

  // Sequencer: accept start outside RUN, step one slice per RUN cycle, commit on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= A;
            b_r     <= op_b_s;
            carry_r <= op_carry_s;
            k_r     <= '0;
            acc_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: requests while busy are dropped.
          acc_r   <= acc_next_s;
          carry_r <= slice_cout_s;
          if (k_r == K_LAST) begin
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= acc_next_s;
            cout_r  <= slice_cout_s;
            state_r <= DONE;
          end else begin
            k_r     <= k_r + KW'(1);
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (N=8, WORDS=4): directed table,
// multi-cycle corner sequences and random operations against an arithmetic model.
module tb_rca_seq_ctrl;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Cin   = 1'b0;
`ifdef RCA_SEQ_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         Cout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef RCA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  // Reference result: {carry, sum} of the full-width arithmetic.
  function automatic logic [W:0] ref_res(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic s);
    logic [W:0] t;
    if (s) t = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else   t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation (caller sits just after a rising edge) and check timing and result.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input bit mid);
    int           cyc;
    int           busy_cnt;
    bit           stable;
    logic [W-1:0] prev;
    logic [W-1:0] got;
    prev   = sum;
    stable = 1'b1;
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (sum !== prev) stable = 1'b0;
      if (mid && cyc == 1) begin
        A = ~a; B = a ^ 32'h5A5A_0F0F; Cin = ~cin; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({name, "_latency"}, cyc, 4);
    check({name, "_busy_cycles"}, busy_cnt, 4);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_hold_in_run"}, stable, 1);
    check({name, "_sum"}, sum, exp_sum);
    check({name, "_cout"}, Cout, exp_cout);
    got = sum;
    @(posedge clk); #1;
    check({name, "_done_single"}, done, 0);
    check({name, "_idle_after"}, busy, 0);
    check({name, "_sum_stable"}, sum, got);
  endtask

  vec_t         vecs[6];
  logic [W:0]   e;
  logic [W-1:0] pa[3];
  logic [W-1:0] pb[3];
  logic         pc[3];
  logic [W:0]   pe[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", Cout, 0);
    rst_n = 1'b1;

    // Directed table; the first op starts on the first edge after reset release.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);
    end

    // Start pulsed mid-RUN with different operands is ignored.
    run_op("midstart", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b1);

    // Reset asserted in the second RUN cycle abandons the operation.
    A = 32'hDEAD_BEEF; B = 32'h0101_0101; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstrun_busy", busy, 0);
    check("rstrun_done", done, 0);
    check("rstrun_sum", sum, 0);
    check("rstrun_cout", Cout, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rstrun_done_held", done, 0);
    rst_n = 1'b1;
    run_op("after_rst", 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 32'h1010_1011, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    sub = 1'b1;
    run_op("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    // Start held high through DONE: back-to-back operations, done every 5 cycles.
    pa[0] = 32'h1234_5678; pb[0] = 32'h1111_1111; pc[0] = 1'b0;
    pa[1] = 32'hFFFF_FFFF; pb[1] = 32'h0000_0001; pc[1] = 1'b0;
    pa[2] = 32'hA5A5_A5A5; pb[2] = 32'h5A5A_5A5A; pc[2] = 1'b1;
    for (int j = 0; j < 3; j++) pe[j] = ref_res(pa[j], pb[j], pc[j], 1'b0);
    begin
      int j;
      int last;
      j    = 0;
      last = 0;
      A = pa[0]; B = pb[0]; Cin = pc[0]; start = 1'b1;
      for (int cyc = 0; cyc < 40 && j < 3; cyc++) begin
        @(posedge clk); #1;
        if (done) begin
          check($sformatf("b2b%0d_sum", j), sum, pe[j][W-1:0]);
          check($sformatf("b2b%0d_cout", j), Cout, pe[j][W]);
          if (j > 0) check($sformatf("b2b%0d_gap", j), cyc - last, 5);
          last = cyc;
          j++;
          if (j < 3) begin
            A = pa[j]; B = pb[j]; Cin = pc[j];
          end else begin
            start = 1'b0;
          end
        end
      end
      start = 1'b0;
      check("b2b_count", j, 3);
      repeat (6) @(posedge clk);
      #1;
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      rs  = 1'($urandom_range(0, 1));
      sub = rs;
`endif
      e = ref_res(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, e[W-1:0], e[W], (i % 5) == 0);
    end
`ifdef RCA_SEQ_SUB_EN
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: width of the single shared ripple-carry adder slice.
REQ-002 SHALL have parameter WORDS, default 4: number of N-bit slices per operation; total width W = N*WORDS; WORDS >= 2.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1: request pulse; accepted only when busy=0.
REQ-006 SHALL have port A, input, W: operand A, sampled on accepted start.
REQ-007 SHALL have port B, input, W: operand B, sampled on accepted start.
REQ-008 SHALL have port Cin, input, 1: carry-in, sampled on accepted start.
REQ-009 SHALL have port busy, output, 1: high while the operation is in progress (RUN state).
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a result is committed.
REQ-011 SHALL have port sum, output, W: registered result of the last completed operation.
REQ-012 SHALL have port Cout, output, 1: registered final carry of the last completed operation.

Function
REQ-013 SHALL instantiate exactly one N-bit ripple-carry adder slice and reuse it once per cycle across all WORDS slices.
REQ-014 SHALL implement states IDLE, RUN and DONE; IDLE->RUN on start; RUN->RUN while slice index k < WORDS-1; RUN->DONE after slice WORDS-1; DONE->IDLE unconditionally, or DONE->RUN if start=1.
REQ-015 SHALL, on accepted start, latch A, B and Cin into operand registers, clear k to 0 and load the carry register with Cin.
REQ-016 SHALL, in each RUN cycle, add slice k of A and B plus the carry register, write the N-bit result to slice k of an internal accumulator, store the slice carry-out in the carry register, and increment k.
REQ-017 SHALL leave sum and Cout unchanged during RUN, then copy the accumulator and final carry to them on the RUN->DONE edge.
REQ-018 SHALL drive done=1 exactly in the DONE cycle; start at edge t gives busy=1 for edges t+1..t+WORDS and done=1 after edge t+WORDS.
REQ-019 SHALL ignore start while busy=1, with no effect on operands, k or outputs.
REQ-020 SHALL compute the result modulo 2^W, with Cout equal to bit W of A+B+Cin.
REQ-021 SHALL keep sum and Cout stable from one done until the next done.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously force IDLE, k=0, carry=0, busy=0, done=0, sum=0 and Cout=0.
REQ-023 SHALL, if reset asserts during RUN, abandon the operation, produce no done pulse and keep all outputs at reset values until the next completed operation.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, when macro RCA_SEQ_SUB_EN is defined, add input port sub (1 bit, sampled on accepted start); sub=1 computes A + ~B + 1 (Cin ignored, carry forced to 1), and Cout=0 indicates a borrow.
REQ-026 SHALL, when RCA_SEQ_SUB_EN is undefined, omit the sub port and perform addition only.

Verification (N=8, WORDS=4)
REQ-027 SHALL check: A=0x12345678, B=0x11111111, Cin=0, start -> after 5 edges done=1, sum=0x23456789, Cout=0.
REQ-028 SHALL check: A=0xFFFFFFFF, B=0x00000001, Cin=0 -> carry ripples through all 4 slices, sum=0x00000000, Cout=1, busy high exactly 4 cycles.
REQ-029 SHALL check: start pulsed again mid-RUN with different operands -> ignored; first result delivered unchanged, single done pulse.
REQ-030 SHALL check: rst_n pulled low at the second RUN cycle -> busy=0, done never pulses, sum=0, Cout=0; a fresh start then completes normally.
REQ-031 SHALL check, with RCA_SEQ_SUB_EN: A=5, B=7, sub=1, Cin=1 -> sum=0xFFFFFFFE, Cout=0; A=7, B=5, sub=1 -> sum=0x00000002, Cout=1.
REQ-032 SHALL check: start held high during DONE -> back-to-back operation, done pulses every 5 cycles.
